// File: rtl/ce_gen.sv
// Multi-channel fractional clock-enable generator: per-channel num/den accumulators with
// shadow/apply reprogramming and a lock flag. Define CE_GEN_SQUARE_EN to add the o_sq output.
module ce_gen #(
    parameter int unsigned  CHANNELS    = 2,
    parameter int unsigned  ACC_W       = 16,
    parameter int unsigned  LOCK_CYCLES = 16,
    localparam int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int unsigned CNT_W       = $clog2(LOCK_CYCLES + 1)
) (
    input  logic                i_refclk,
    input  logic                i_rst,
    input  logic                i_cfg_we,
    input  logic [CH_W-1:0]     i_cfg_ch,
    input  logic [ACC_W-1:0]    i_cfg_num,
    input  logic [ACC_W-1:0]    i_cfg_den,
    input  logic                i_cfg_apply,
    output logic [CHANNELS-1:0] o_ce,
`ifdef CE_GEN_SQUARE_EN
    output logic [CHANNELS-1:0] o_sq,
`endif
    output logic                o_locked
);

    typedef enum logic {StSettle, StLocked} state_t;

    logic w_we_ok;
    assign w_we_ok = i_cfg_we && (32'(i_cfg_ch) < CHANNELS);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [ACC_W-1:0] r_snum, r_sden, r_anum, r_aden, r_acc;
        logic             r_ce;
        logic             w_wr, w_idle, w_sat, w_wrap;
        logic [ACC_W:0]   w_sum, w_diff;
        logic [ACC_W-1:0] w_acc_d;

        assign w_wr    = w_we_ok && (32'(i_cfg_ch) == g);
        assign w_idle  = (r_anum == '0) || (r_aden == '0);
        assign w_sat   = (r_anum >= r_aden);
        // One spare bit keeps acc + anum exact; acc < aden guarantees sum - aden fits.
        assign w_sum   = {1'b0, r_acc} + {1'b0, r_anum};
        assign w_diff  = w_sum - {1'b0, r_aden};
        assign w_wrap  = (w_sum >= {1'b0, r_aden});
        assign w_acc_d = w_wrap ? w_diff[ACC_W-1:0] : w_sum[ACC_W-1:0];

        always_ff @(posedge i_refclk) begin
            if (i_rst) begin
                r_snum <= '0;
                r_sden <= '0;
                r_anum <= '0;
                r_aden <= '0;
                r_acc  <= '0;
                r_ce   <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_snum <= i_cfg_num;
                    r_sden <= i_cfg_den;
                end
                if (i_cfg_apply) begin
                    // Same-edge write is forwarded straight into the active copy.
                    r_anum <= w_wr ? i_cfg_num : r_snum;
                    r_aden <= w_wr ? i_cfg_den : r_sden;
                    r_acc  <= '0;
                    r_ce   <= 1'b0;
                end else if (w_idle) begin
                    r_acc <= '0;
                    r_ce  <= 1'b0;
                end else if (w_sat) begin
                    r_acc <= '0;
                    r_ce  <= 1'b1;
                end else begin
                    r_acc <= w_acc_d;
                    r_ce  <= w_wrap;
                end
            end
        end

        assign o_ce[g] = r_ce;

`ifdef CE_GEN_SQUARE_EN
        logic r_sq;

        always_ff @(posedge i_refclk) begin
            if (i_rst || i_cfg_apply || w_idle || w_sat) begin
                r_sq <= 1'b0;
            end else begin
                r_sq <= (w_acc_d >= (r_aden >> 1));
            end
        end

        assign o_sq[g] = r_sq;
`endif
    end

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_locked;

    always_ff @(posedge i_refclk) begin
        if (i_rst || i_cfg_apply) begin
            r_state  <= StSettle;
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else begin
            case (r_state)
                StSettle: begin
                    if (r_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                        r_state  <= StLocked;
                        r_locked <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StLocked: r_locked <= 1'b1;
                default: begin
                    r_state  <= StSettle;
                    r_cnt    <= '0;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign o_locked = r_locked;

endmodule

// File: tb/tb_ce_gen.sv
// Self-checking bench for ce_gen: closed-form pulse model (floor(n*num/den) steps) feeding a
// scoreboard queue, plus pulse-count and gap checks on the rate scenarios.
module tb_ce_gen;
    localparam int CH  = 3;
    localparam int AW  = 16;
    localparam int LC  = 16;
    localparam int CHW = 2;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [AW-1:0] cfg_num;
    logic [AW-1:0] cfg_den;
    logic          cfg_apply;
    logic [CH-1:0] ce;
    logic          locked;
`ifdef CE_GEN_SQUARE_EN
    logic [CH-1:0] sq;
`endif

    ce_gen #(
        .CHANNELS    (CH),
        .ACC_W       (AW),
        .LOCK_CYCLES (LC)
    ) dut (
        .i_refclk    (clk),
        .i_rst       (rst),
        .i_cfg_we    (cfg_we),
        .i_cfg_ch    (cfg_ch),
        .i_cfg_num   (cfg_num),
        .i_cfg_den   (cfg_den),
        .i_cfg_apply (cfg_apply),
        .o_ce        (ce),
`ifdef CE_GEN_SQUARE_EN
        .o_sq        (sq),
`endif
        .o_locked    (locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference state: shadows, applied ratios, cycles since last apply/reset release.
    longint m_snum [CH];
    longint m_sden [CH];
    longint m_anum [CH];
    longint m_aden [CH];
    longint m_n;
    logic [CH:0] sb_q [$];

    int cnt [CH];
    int cyc, last1, gap_min, gap_max;

    function automatic logic [CH:0] model_out();
        logic [CH:0] e;
        e = '0;
        for (int i = 0; i < CH; i++) begin
            if (m_n == 0 || m_anum[i] == 0 || m_aden[i] == 0) e[i] = 1'b0;
            else if (m_anum[i] >= m_aden[i])                  e[i] = 1'b1;
            else e[i] = ((m_n * m_anum[i]) / m_aden[i]) != (((m_n - 1) * m_anum[i]) / m_aden[i]);
        end
        e[CH] = (m_n >= LC);
        return e;
    endfunction

    task automatic clear_stats();
        for (int i = 0; i < CH; i++) cnt[i] = 0;
        cyc = 0;
        last1 = -1;
        gap_min = 1000000;
        gap_max = 0;
    endtask

    task automatic cycle();
        logic [CH:0] exp;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_snum[i] = 0; m_sden[i] = 0; m_anum[i] = 0; m_aden[i] = 0;
            end
            m_n = 0;
        end else begin
            if (cfg_we && int'(cfg_ch) < CH) begin
                m_snum[cfg_ch] = longint'(cfg_num);
                m_sden[cfg_ch] = longint'(cfg_den);
            end
            if (cfg_apply) begin
                for (int i = 0; i < CH; i++) begin
                    m_anum[i] = m_snum[i];
                    m_aden[i] = m_sden[i];
                end
                m_n = 0;
            end else begin
                m_n++;
            end
        end
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        exp = sb_q.pop_front();
        check_eq("out", 32'({locked, ce}), 32'(exp));
        cyc++;
        for (int i = 0; i < CH; i++) cnt[i] += int'(ce[i]);
        if (ce[1]) begin
            if (last1 >= 0) begin
                if (cyc - last1 < gap_min) gap_min = cyc - last1;
                if (cyc - last1 > gap_max) gap_max = cyc - last1;
            end
            last1 = cyc;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write_ch(input int ch, input int num, input int den);
        cfg_we = 1'b1; cfg_ch = CHW'(ch); cfg_num = AW'(num); cfg_den = AW'(den);
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic apply();
        cfg_apply = 1'b1;
        cycle();
        cfg_apply = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_num = '0; cfg_den = '0; cfg_apply = 1'b0;
        clear_stats();
        run(3);
        check_eq("rst_ce", 32'(ce), 0);
        check_eq("rst_locked", 32'(locked), 0);

        // Release: locked rises on the 16th edge, channels idle.
        rst = 1'b0;
        run(15);
        check_eq("pre_lock", 32'(locked), 0);
        run(1);
        check_eq("lock_16", 32'(locked), 1);
        check_eq("idle_cnt", 32'(cnt[0] + cnt[1] + cnt[2]), 0);

        // Ch0 1/4: first pulse after T+4, 25 in 100.
        write_ch(0, 1, 4);
        check_eq("shadow_no_effect", 32'(ce), 0);
        apply();
        clear_stats();
        run(3);
        check_eq("ch0_before_first", 32'(cnt[0]), 0);
        run(1);
        check_eq("ch0_first_T4", 32'(ce[0]), 1);
        run(96);
        check_eq("ch0_25_in_100", 32'(cnt[0]), 25);

        // Ch1 5/96: 500 pulses in 9600 cycles, gaps of 19/20.
        write_ch(1, 5, 96);
        apply();
        clear_stats();
        run(9600);
        check_eq("ch1_500", 32'(cnt[1]), 500);
        check_eq("ch1_gap_min", 32'(gap_min), 19);
        check_eq("ch1_gap_max", 32'(gap_max), 20);
        check_eq("ch0_2400", 32'(cnt[0]), 2400);

        // Re-apply identical ratios mid-run: realign and relock.
        write_ch(0, 1, 3);
        write_ch(1, 2, 6);
        apply();
        run(5);
        apply();
        check_eq("reapply_ce_low", 32'(ce), 0);
        check_eq("reapply_unlock", 32'(locked), 0);
        run(15);
        check_eq("reapply_still_unlocked", 32'(locked), 0);
        run(1);
        check_eq("reapply_relock", 32'(locked), 1);

        // Same-edge write + apply is forwarded; out-of-range channel write ignored.
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_num = 16'd7; cfg_den = 16'd7; cfg_apply = 1'b1;
        cycle();
        cfg_we = 1'b0; cfg_apply = 1'b0;
        check_eq("fwd_ce_cleared", 32'(ce[0]), 0);
        run(1);
        check_eq("fwd_sat_T1", 32'(ce[0]), 1);
        write_ch(3, 1, 2);
        apply();
        clear_stats();
        run(12);
        check_eq("sat_cnt", 32'(cnt[0]), 12);
        check_eq("ch1_unchanged", 32'(cnt[1]), 4);
        check_eq("ch2_ignored", 32'(cnt[2]), 0);

        // Reset wins over apply on the same edge and clears shadows.
        write_ch(1, 1, 2);
        write_ch(2, 1, 2);
        rst = 1'b1; cfg_apply = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_num = 16'd1; cfg_den = 16'd2;
        cycle();
        rst = 1'b0; cfg_apply = 1'b0; cfg_we = 1'b0;
        check_eq("rst_apply_out", 32'({locked, ce}), 0);
        apply();
        clear_stats();
        run(20);
        check_eq("post_rst_idle", 32'(cnt[0] + cnt[1] + cnt[2]), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
